// File: rtl/ysyx_22041412_icache.sv
// rtl/ysyx_22041412_icache.sv - direct-mapped 128-bit-line instruction cache with two-beat refill
module ysyx_22041412_icache #(
  parameter int LINES = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid_i,
  input  logic [31:0]  addr_i,
  output logic         ready_o,
  output logic [127:0] data_o,
  input  logic         clean_i,
  output logic         clear_o,
  input  logic         fence_i,
  output logic         fence_done_o,
  output logic         mem_req_o,
  output logic [31:0]  mem_addr_o,
  input  logic         mem_ack_i,
  input  logic [63:0]  mem_rdata_i
);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 28 - IDX_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_REFILL,
    S_RESP,
    S_FENCE
  } state_e;

  state_e             state_q;
  logic [27:0]        line_addr_q;
  logic [LINES-1:0]   valid_q;
  logic               abort_q;
  logic               fence_pend_q;
  logic               beat_q;
  logic [63:0]        beat0_q;
  logic [127:0]       line_q;
  logic [127:0]       data_q;
  logic               ready_q;
  logic               clear_q;
  logic               fence_done_q;
  logic               mem_req_q;
  logic [31:0]        mem_addr_q;

  logic [TAG_W-1:0]   tag_mem  [LINES];
  logic [127:0]       data_mem [LINES];

  logic [IDX_W-1:0]   idx;
  logic [TAG_W-1:0]   tag;
  logic               hit;
  logic               wr_en;
  logic               busy;
  logic               unused_addr_bits;

  assign idx              = line_addr_q[IDX_W-1:0];
  assign tag              = line_addr_q[27:IDX_W];
  assign hit              = valid_q[idx] && (tag_mem[idx] == tag);
  assign wr_en            = (state_q == S_REFILL) && mem_ack_i && beat_q;
  assign busy             = (state_q == S_LOOKUP) || (state_q == S_REFILL) || (state_q == S_RESP);
  assign unused_addr_bits = ^addr_i[3:0];

  assign ready_o      = ready_q;
  assign data_o       = data_q;
  assign clear_o      = clear_q;
  assign fence_done_o = fence_done_q;
  assign mem_req_o    = mem_req_q;
  assign mem_addr_o   = mem_addr_q;

  // Tag/data arrays carry no reset so they can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[idx]  <= tag;
      data_mem[idx] <= {mem_rdata_i, beat0_q};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      line_addr_q  <= '0;
      valid_q      <= '0;
      abort_q      <= 1'b0;
      fence_pend_q <= 1'b0;
      beat_q       <= 1'b0;
      beat0_q      <= '0;
      line_q       <= '0;
      data_q       <= '0;
      ready_q      <= 1'b0;
      clear_q      <= 1'b1;
      fence_done_q <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
    end else begin
      ready_q      <= 1'b0;
      fence_done_q <= 1'b0;
      if (busy && fence_i) fence_pend_q <= 1'b1;
      if (busy && clean_i) abort_q <= 1'b1;

      case (state_q)
        S_IDLE: begin
          if (fence_i || fence_pend_q) begin
            fence_pend_q <= 1'b0;
            clear_q      <= 1'b0;
            state_q      <= S_FENCE;
          end else if (valid_i && !clean_i) begin
            line_addr_q <= addr_i[31:4];
            clear_q     <= 1'b0;
            state_q     <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (hit) begin
            line_q  <= data_mem[idx];
            state_q <= S_RESP;
          end else begin
            mem_req_q  <= 1'b1;
            mem_addr_q <= {line_addr_q, 4'h0};
            beat_q     <= 1'b0;
            state_q    <= S_REFILL;
          end
        end
        S_REFILL: begin
          // An abort never cuts the refill short: both beats land in the array.
          if (mem_ack_i) begin
            if (!beat_q) begin
              beat0_q    <= mem_rdata_i;
              beat_q     <= 1'b1;
              mem_addr_q <= {line_addr_q, 4'h8};
            end else begin
              valid_q[idx] <= 1'b1;
              line_q       <= {mem_rdata_i, beat0_q};
              mem_req_q    <= 1'b0;
              state_q      <= S_RESP;
            end
          end
        end
        S_RESP: begin
          if (!abort_q && !clean_i) begin
            ready_q <= 1'b1;
            data_q  <= line_q;
          end
          abort_q <= 1'b0;
          clear_q <= 1'b1;
          state_q <= S_IDLE;
        end
        S_FENCE: begin
          valid_q      <= '0;
          fence_done_q <= 1'b1;
          clear_q      <= 1'b1;
          state_q      <= S_IDLE;
        end
        default: begin
          clear_q <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ysyx_22041412_icache.sv
// tb/tb_ysyx_22041412_icache.sv - directed self-checking bench for ysyx_22041412_icache
module tb_ysyx_22041412_icache;
  logic         clk;
  logic         rst;
  logic         valid_i;
  logic [31:0]  addr_i;
  logic         ready_o;
  logic [127:0] data_o;
  logic         clean_i;
  logic         clear_o;
  logic         fence_i;
  logic         fence_done_o;
  logic         mem_req_o;
  logic [31:0]  mem_addr_o;
  logic         mem_ack_i;
  logic [63:0]  mem_rdata_i;

  int checks = 0;
  int errors = 0;

  ysyx_22041412_icache #(.LINES(64)) dut (
    .clk          (clk),
    .rst          (rst),
    .valid_i      (valid_i),
    .addr_i       (addr_i),
    .ready_o      (ready_o),
    .data_o       (data_o),
    .clean_i      (clean_i),
    .clear_o      (clear_o),
    .fence_i      (fence_i),
    .fence_done_o (fence_done_o),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_ack_i    (mem_ack_i),
    .mem_rdata_i  (mem_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one fetch from a negedge; the memory model acks each beat with a one-cycle gap.
  // Cycle n in the loop is the negedge after the n-th posedge following the request.
  task automatic fetch(input logic [31:0] addr, input logic [63:0] a, input logic [63:0] b,
                       input bit miss, input bit abort, input logic [127:0] exp_line);
    int cyc, beats, ready_cyc, ack_cyc, post;
    bit done;
    logic [31:0] exp_addr;
    valid_i = 1'b1;
    addr_i  = addr;
    beats = 0; ready_cyc = -1; ack_cyc = -1; post = 0; done = 1'b0; cyc = 0;
    while (!done && cyc < 60) begin
      @(negedge clk);
      cyc++;
      clean_i = 1'b0;
      if (mem_ack_i) begin
        mem_ack_i = 1'b0;
        if (abort && beats == 1) begin
          clean_i = 1'b1;
          valid_i = 1'b0;
        end
      end else if (mem_req_o) begin
        exp_addr = {addr[31:4], 4'h0} + ((beats != 0) ? 32'd8 : 32'd0);
        check("mem_addr", 128'(mem_addr_o), 128'(exp_addr));
        mem_ack_i   = 1'b1;
        mem_rdata_i = (beats != 0) ? b : a;
        beats++;
        if (beats == 2) ack_cyc = cyc;
      end
      if (ready_o) begin
        ready_cyc = cyc;
        valid_i   = 1'b0;
      end
      if (!abort && ready_cyc > 0) done = 1'b1;
      if (abort && beats == 2 && !mem_ack_i && clear_o) begin
        post++;
        if (post == 4) done = 1'b1;
      end
    end
    check("timeout", 128'(done), 128'(1));
    check("beats", 128'(beats), miss ? 128'(2) : 128'(0));
    if (abort) begin
      check("ready_suppressed", 128'(ready_cyc == -1), 128'(1));
      check("clear_after_abort", 128'(clear_o), 128'(1));
    end else begin
      check("ready_latency", 128'(ready_cyc), miss ? 128'(ack_cyc + 2) : 128'(3));
      check("data", data_o, exp_line);
      @(negedge clk);
      check("ready_one_cycle", {126'(0), ready_o, clear_o}, 128'(1));
    end
    valid_i = 1'b0;
    clean_i = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b0; valid_i = 1'b0; addr_i = '0; clean_i = 1'b0;
    fence_i = 1'b0; mem_ack_i = 1'b0; mem_rdata_i = '0;
    @(negedge clk);
    check("rst_ready", 128'(ready_o), 128'(0));
    check("rst_data", data_o, 128'(0));
    check("rst_req_addr", {95'(0), mem_req_o, mem_addr_o}, 128'(0));
    check("rst_clear_fence", {126'(0), clear_o, fence_done_o}, 128'(2));
    rst = 1'b1;
    @(negedge clk);

    // Cold miss, then a hit on another word of the same line.
    fetch(32'h8000_0000, 64'h1111, 64'h2222, 1'b1, 1'b0, {64'h2222, 64'h1111});
    fetch(32'h8000_000C, 64'h0,    64'h0,    1'b0, 1'b0, {64'h2222, 64'h1111});

    // Same index, different tag: evicts and re-misses.
    fetch(32'h8000_0400, 64'h3333, 64'h4444, 1'b1, 1'b0, {64'h4444, 64'h3333});
    fetch(32'h8000_0000, 64'h5555, 64'h6666, 1'b1, 1'b0, {64'h6666, 64'h5555});

    // clean_i in IDLE blocks acceptance.
    valid_i = 1'b1; addr_i = 32'h8000_0030; clean_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_clean", {126'(0), clear_o, mem_req_o}, 128'(2));
    end
    valid_i = 1'b0; clean_i = 1'b0;
    @(negedge clk);

    // Abort after beat0: refill completes silently, then the line hits.
    fetch(32'h8000_0010, 64'h7777, 64'h8888, 1'b1, 1'b1, 128'(0));
    fetch(32'h8000_0014, 64'h0,    64'h0,    1'b0, 1'b0, {64'h8888, 64'h7777});

    // Fence and request together: fence first, then the request misses.
    fence_i = 1'b1; valid_i = 1'b1; addr_i = 32'h8000_0010;
    @(negedge clk);
    check("fence_state", {125'(0), clear_o, fence_done_o, mem_req_o}, 128'(0));
    @(negedge clk);
    check("fence_done", {126'(0), fence_done_o, clear_o}, 128'(3));
    fence_i = 1'b0;
    fetch(32'h8000_0010, 64'h9999, 64'hAAAA, 1'b1, 1'b0, {64'hAAAA, 64'h9999});

    // Reset mid-refill.
    valid_i = 1'b1; addr_i = 32'h8000_0020;
    n = 0;
    while (!mem_req_o && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("refill_started", 128'(mem_req_o), 128'(1));
    rst = 1'b0; valid_i = 1'b0;
    #1;
    check("rst_mid_refill", {125'(0), mem_req_o, ready_o, clear_o}, 128'(1));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    fetch(32'h8000_0020, 64'hBBBB, 64'hCCCC, 1'b1, 1'b0, {64'hCCCC, 64'hBBBB});
    fetch(32'h8000_0010, 64'hDDDD, 64'hEEEE, 1'b1, 1'b0, {64'hEEEE, 64'hDDDD});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
